// File: rtl/cpu_datapath.sv
// -----------------------------------------------------------------------------
// cpu_datapath
//   Datapath slave for a small accumulator CPU. It holds the program counter,
//   instruction register, accumulator, four general registers, the ALU and
//   the Z/C flags. It performs exactly what the controller strobes command in
//   the cycle they are asserted and makes no sequencing decisions itself.
//
// Parameters
//   DW  data / accumulator / register width (>= 4)
//   AW  program counter / instruction memory address width
//
// Ports
//   clk        system clock, all state updates on the rising edge
//   CLB        asynchronous active-high reset
//   imem_data  instruction / immediate byte at imem_addr (combinational memory)
//   LoadIR     IR <= imem_data
//   IncPC      PC <= PC + 1 (wraps)
//   SelPC      jump source: 0 immediate (imem_data), 1 register R[ir[1:0]]
//   LoadPC     PC <= selected jump source (wins over IncPC)
//   LoadReg    R[ir[1:0]] <= ACC (value before the edge)
//   LoadAcc    ACC <= source chosen by SelACC
//   SelACC     00 ALU, 01 R[ir[1:0]], 10 immediate, 11 hold
//   SelALU     ALU function: 0001 ADD, 0010 SUB, 0011 NOR, 1011 SHL, 1100 SHR
//   op         ir[7:4]
//   z, c       registered zero / carry flags
//   imem_addr  current PC
//   acc_out    current ACC
//   pc_ovf     (only when PC_OVF_EN is defined) sticky PC wrap indicator
//
// Optional build macro
//   PC_OVF_EN  adds the pc_ovf output, set when IncPC alone wraps PC to 0 and
//              cleared only by CLB. Without it PC wraps silently.
//
// Interface timing: there is no handshake. Every strobe is a single-cycle
// command sampled on the rising edge of clk; its effect is visible on the
// outputs right after that edge. All outputs come straight from registers.
// -----------------------------------------------------------------------------
module cpu_datapath #(
    parameter int DW = 8,
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          CLB,
    input  logic [7:0]    imem_data,
    input  logic          LoadIR,
    input  logic          IncPC,
    input  logic          SelPC,
    input  logic          LoadPC,
    input  logic          LoadReg,
    input  logic          LoadAcc,
    input  logic [1:0]    SelACC,
    input  logic [3:0]    SelALU,
    output logic [3:0]    op,
    output logic          z,
    output logic          c,
    output logic [AW-1:0] imem_addr,
    output logic [DW-1:0] acc_out
`ifdef PC_OVF_EN
    ,
    output logic          pc_ovf
`endif
);

    localparam logic [3:0] ALU_ADD = 4'b0001;
    localparam logic [3:0] ALU_SUB = 4'b0010;
    localparam logic [3:0] ALU_NOR = 4'b0011;
    localparam logic [3:0] ALU_SHL = 4'b1011;
    localparam logic [3:0] ALU_SHR = 4'b1100;

    // Only the opcode and register-index fields of IR are ever used, so
    // ir[3:2] is not stored.
    logic [AW-1:0] pc_q;
    logic [3:0]    ir_op_q;
    logic [1:0]    ir_idx_q;
    logic [DW-1:0] acc_q;
    logic [DW-1:0] regs_q [4];
    logic          z_q;
    logic          c_q;

    logic [DW-1:0] r_sel;
    logic [DW-1:0] imm_dw;
    logic [AW-1:0] jmp_target;
    logic [DW:0]   alu_wide;
    logic          alu_c;
    logic          alu_defined;
    logic [DW-1:0] acc_next;

    assign r_sel      = regs_q[ir_idx_q];
    // Size casts zero-extend the byte for wide datapaths and truncate it for
    // narrow ones; the same applies to jump targets versus the PC width.
    assign imm_dw     = DW'(imem_data);
    assign jmp_target = SelPC ? AW'(r_sel) : AW'(imem_data);

    // ALU with one extra bit so ADD carry and SUB borrow both fall out of
    // bit DW of the wide result.
    always_comb begin
        alu_wide    = {1'b0, acc_q};
        alu_c       = c_q;
        alu_defined = 1'b0;
        case (SelALU)
            ALU_ADD: begin
                alu_wide    = {1'b0, acc_q} + {1'b0, r_sel};
                alu_c       = alu_wide[DW];
                alu_defined = 1'b1;
            end
            ALU_SUB: begin
                alu_wide    = {1'b0, acc_q} - {1'b0, r_sel};
                alu_c       = alu_wide[DW];
                alu_defined = 1'b1;
            end
            ALU_NOR: begin
                alu_wide    = {1'b0, ~(acc_q | r_sel)};
                alu_c       = 1'b0;
                alu_defined = 1'b1;
            end
            ALU_SHL: begin
                alu_wide    = {acc_q, 1'b0};
                alu_c       = acc_q[DW-1];
                alu_defined = 1'b1;
            end
            ALU_SHR: begin
                alu_wide    = {2'b00, acc_q[DW-1:1]};
                alu_c       = acc_q[0];
                alu_defined = 1'b1;
            end
            default: begin
                alu_wide    = {1'b0, acc_q};
                alu_c       = c_q;
                alu_defined = 1'b0;
            end
        endcase
    end

    always_comb begin
        acc_next = acc_q;
        case (SelACC)
            2'b00:   acc_next = alu_wide[DW-1:0];
            2'b01:   acc_next = r_sel;
            2'b10:   acc_next = imm_dw;
            default: acc_next = acc_q;
        endcase
    end

    // Program counter: LoadPC has priority over IncPC.
    always_ff @(posedge clk or posedge CLB) begin
        if (CLB) begin
            pc_q <= '0;
        end else if (LoadPC) begin
            pc_q <= jmp_target;
        end else if (IncPC) begin
            pc_q <= pc_q + AW'(1);
        end
    end

    // IR samples the byte at the pre-edge PC even if PC moves on this edge.
    always_ff @(posedge clk or posedge CLB) begin
        if (CLB) begin
            ir_op_q  <= '0;
            ir_idx_q <= '0;
        end else if (LoadIR) begin
            ir_op_q  <= imem_data[7:4];
            ir_idx_q <= imem_data[1:0];
        end
    end

    // Accumulator and flags. SelACC=11 leaves ACC, z and c untouched.
    always_ff @(posedge clk or posedge CLB) begin
        if (CLB) begin
            acc_q <= '0;
            z_q   <= 1'b0;
            c_q   <= 1'b0;
        end else if (LoadAcc && (SelACC != 2'b11)) begin
            acc_q <= acc_next;
            z_q   <= (acc_next == '0);
            if ((SelACC == 2'b00) && alu_defined) begin
                c_q <= alu_c;
            end
        end
    end

    // Register file write uses the pre-edge ACC, which makes a same-cycle
    // LoadReg + LoadAcc(SelACC=01) a swap.
    always_ff @(posedge clk or posedge CLB) begin
        if (CLB) begin
            for (int i = 0; i < 4; i++) begin
                regs_q[i] <= '0;
            end
        end else if (LoadReg) begin
            regs_q[ir_idx_q] <= acc_q;
        end
    end

`ifdef PC_OVF_EN
    logic pc_ovf_q;

    always_ff @(posedge clk or posedge CLB) begin
        if (CLB) begin
            pc_ovf_q <= 1'b0;
        end else if (IncPC && !LoadPC && (pc_q == '1)) begin
            pc_ovf_q <= 1'b1;
        end
    end

    assign pc_ovf = pc_ovf_q;
`endif

    assign op        = ir_op_q;
    assign z         = z_q;
    assign c         = c_q;
    assign imem_addr = pc_q;
    assign acc_out   = acc_q;

endmodule
